fp_div: RTL and testbench

- Iterative signed fixed-point divider: quotient = dividend / divisor, two's-complement Q(WIDTH-FRAC_WIDTH).FRAC_WIDTH.
- Inverse-direction companion to the saturating fixed-point adder. Computes by restoring shift-and-subtract, one quotient bit per cycle.
- Same clipping rules as the adder: results saturate to the max/min code and raise ovrflw.
- Used by the raycaster datapath for distance/step ratios; valid/ready on both sides.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_div_if.sv | 30 +++
 rtl/fp_sat_sign.sv | 40 ++++
 rtl/fp_div.sv | 162 ++++++++++++++++
 tb/tb_fp_div.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared fixed-point package: FSM state type, default geometry and the
// saturation-code helpers reused by the fixed-point adder/divider family.
package fp_pkg;

    localparam int FP_WIDTH_DEF = 16;
    localparam int FP_FRAC_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fp_div_state_t;

    // Largest positive two's-complement code for a given width (0x7FFF at 16 bits).
    function automatic logic [63:0] fp_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative code for a given width (0x8000 at 16 bits), as its unsigned magnitude.
    function automatic logic [63:0] fp_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fp_div_if.sv
// Operand/result bus of the fixed-point divider.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and its payload stable until that
// edge; ready may change freely and never depends combinationally on valid.
// Input side: in_valid/in_ready carry dividend/divisor. Output side:
// out_valid/out_ready carry quotient/ovrflw/div_zero.
interface fp_div_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic             ovrflw;
    logic             div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, ovrflw, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, ovrflw, div_zero
    );
endinterface

// File: rtl/fp_sat_sign.sv
// Applies the result sign to an unsigned quotient magnitude and clips it to
// the representable two's-complement range, flagging any clipping.
module fp_sat_sign
    import fp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QW    = 24
) (
    input  logic [QW-1:0]    q_mag,
    input  logic             sign,
    output logic [WIDTH-1:0] quotient,
    output logic             ovrflw
);

    localparam logic [WIDTH-1:0] MAX_CODE = WIDTH'(fp_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_CODE = WIDTH'(fp_min(WIDTH));
    localparam logic [QW-1:0]    POS_LIM  = QW'(fp_max(WIDTH));
    localparam logic [QW-1:0]    NEG_LIM  = QW'(fp_min(WIDTH));

    logic [WIDTH-1:0] q_low;

    // Clip against the sign-dependent limit, otherwise negate as needed.
    always_comb begin
        quotient = '0;
        ovrflw   = 1'b0;
        q_low    = q_mag[WIDTH-1:0];
        if (!sign && (q_mag > POS_LIM)) begin
            quotient = MAX_CODE;
            ovrflw   = 1'b1;
        end else if (sign && (q_mag > NEG_LIM)) begin
            quotient = MIN_CODE;
            ovrflw   = 1'b1;
        end else if (sign) begin
            quotient = -q_low;
        end else begin
            quotient = q_low;
        end
    end

endmodule

// File: rtl/fp_div.sv
// Iterative signed fixed-point divider (restoring shift-and-subtract, one
// quotient bit per cycle) with saturating output.
// Optional macro FP_DIV_ROUND_EN: round half away from zero instead of
// truncating toward zero; latency is the same either way.
module fp_div
    import fp_pkg::*;
#(
    parameter int WIDTH      = FP_WIDTH_DEF,
    parameter int FRAC_WIDTH = FP_FRAC_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    fp_div_if.slave       bus,
    output fp_div_state_t state_dbg
);

    // Quotient bits produced: integer bits plus the fractional shift.
    localparam int N  = WIDTH + FRAC_WIDTH;
    localparam int CW = $clog2(N + 1);
    // Counter value of the extra cycle that registers the saturated result.
    localparam logic [CW-1:0] LAST = CW'(N);

    localparam logic [WIDTH-1:0] MAX_CODE = WIDTH'(fp_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_CODE = WIDTH'(fp_min(WIDTH));

    fp_div_state_t state, next_state;

    logic [CW-1:0]    cnt;
    logic [N-1:0]     num_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dmag_q;
    logic [N-1:0]     q_q;
    logic             sign_q;
    logic [WIDTH-1:0] quotient_q;
    logic             ovrflw_q;
    logic             div_zero_q;

    logic             accept;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] rem_wide;
    logic [WIDTH+1:0] dmag_ext;
    logic             rem_ge;
    logic [WIDTH:0]   rem_next;
    logic [N-1:0]     q_final;
    logic [WIDTH-1:0] sat_quot;
    logic             sat_ovf;

    assign accept        = bus.in_valid && (state == IDLE);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.ovrflw    = ovrflw_q;
    assign bus.div_zero  = div_zero_q;
    assign state_dbg     = state;

    // Operand magnitudes; the most negative code maps onto itself as an unsigned value.
    assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    // One restoring step: bring in the next numerator bit, subtract if it fits.
    always_comb begin
        rem_wide = {rem_q, num_q[N-1]};
        dmag_ext = {2'b00, dmag_q};
        rem_ge   = (rem_wide >= dmag_ext);
        rem_next = rem_ge ? (WIDTH + 1)'(rem_wide - dmag_ext) : (WIDTH + 1)'(rem_wide);
    end

    // Final quotient magnitude fed to the saturation stage.
    always_comb begin
        q_final = q_q;
`ifdef FP_DIV_ROUND_EN
        if ({rem_q, 1'b0} >= {2'b00, dmag_q}) begin
            q_final = q_q + N'(1);
        end
`endif
    end

    fp_sat_sign #(
        .WIDTH (WIDTH),
        .QW    (N)
    ) u_sat (
        .q_mag    (q_final),
        .sign     (sign_q),
        .quotient (sat_quot),
        .ovrflw   (sat_ovf)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: divide-by-zero skips the iterations entirely.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    next_state = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, register the clipped result.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt        <= '0;
            num_q      <= '0;
            rem_q      <= '0;
            dmag_q     <= '0;
            q_q        <= '0;
            sign_q     <= 1'b0;
            quotient_q <= '0;
            ovrflw_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            // A zero dividend carries no sign so the result is never a negative zero.
            sign_q     <= (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]) && (bus.dividend != '0);
            dmag_q     <= dvs_mag;
            num_q      <= {dvd_mag, {FRAC_WIDTH{1'b0}}};
            rem_q      <= '0;
            q_q        <= '0;
            cnt        <= '0;
            ovrflw_q   <= 1'b0;
            div_zero_q <= 1'b0;
            if (bus.divisor == '0) begin
                quotient_q <= bus.dividend[WIDTH-1] ? MIN_CODE : MAX_CODE;
                ovrflw_q   <= 1'b1;
                div_zero_q <= 1'b1;
            end
        end else if (state == CALC) begin
            if (cnt == LAST) begin
                quotient_q <= sat_quot;
                ovrflw_q   <= sat_ovf;
                cnt        <= '0;
            end else begin
                rem_q <= rem_next;
                q_q   <= {q_q[N-2:0], rem_ge};
                num_q <= {num_q[N-2:0], 1'b0};
                cnt   <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// Directed testbench for fp_div at WIDTH=16, FRAC_WIDTH=8 (Q8.8).
module tb_fp_div;
    import fp_pkg::*;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fp_div_if #(.WIDTH(W)) bus ();
    fp_div_state_t state_dbg;

    fp_div #(
        .WIDTH      (16),
        .FRAC_WIDTH (8)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        ov;
    } vec_t;

    // Driver: present operands from IDLE, wait for the result with a bounded
    // cycle budget, capture it, then complete the output handshake.
    // lat counts clock edges after the accept edge; -1 means the budget expired.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic ov, output logic dz,
                          output int lat, output logic busy_ok);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        busy_ok       = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        q  = bus.quotient;
        ov = bus.ovrflw;
        dz = bus.div_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst_n = 1'b0;
        #13;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 16'h0000 ||
            bus.ovrflw !== 1'b0 || bus.div_zero !== 1'b0 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b q=%h ov=%b dz=%b state=%0d, want 1 0 0000 0 0 IDLE",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.ovrflw, bus.div_zero, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] q;
        logic ov, dz, busy_ok;
        int lat;
        run_op(16'h0300, 16'h0200, q, ov, dz, lat, busy_ok);
        vectors++;
        if (q !== 16'h0180 || ov !== 1'b0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_3_2: q=%h ov=%b dz=%b, want 0180 0 0", q, ov, dz);
        end
        vectors++;
        if (lat !== 25) begin
            errors++;
            $display("FAIL basic_latency: %0d edges, want 25", lat);
        end
        vectors++;
        if (busy_ok !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready: in_ready seen high while busy, want 0");
        end
    endtask

    task automatic test_values();
        vec_t tbl[8];
        logic [15:0] q;
        logic ov, dz, busy_ok;
        int lat;
        tbl[0] = '{16'hFF00, 16'h0400, 16'hFFC0, 1'b0};
`ifdef FP_DIV_ROUND_EN
        tbl[1] = '{16'h0200, 16'h0300, 16'h00AB, 1'b0};
`else
        tbl[1] = '{16'h0200, 16'h0300, 16'h00AA, 1'b0};
`endif
        tbl[2] = '{16'h0000, 16'h0300, 16'h0000, 1'b0};
        tbl[3] = '{16'hFD00, 16'hFE80, 16'h0200, 1'b0};
        tbl[4] = '{16'h0100, 16'hFD00, 16'hFFAB, 1'b0};
        tbl[5] = '{16'h0000, 16'hFF00, 16'h0000, 1'b0};
        tbl[6] = '{16'h0100, 16'h0100, 16'h0100, 1'b0};
        tbl[7] = '{16'hFA00, 16'h0200, 16'hFD00, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, q, ov, dz, lat, busy_ok);
            vectors++;
            if (q !== tbl[i].q || ov !== tbl[i].ov || dz !== 1'b0 || lat !== 25) begin
                errors++;
                $display("FAIL value_%0d %h/%h: q=%h ov=%b dz=%b lat=%0d, want %h %b 0 25",
                         i, tbl[i].a, tbl[i].b, q, ov, dz, lat, tbl[i].q, tbl[i].ov);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t tbl[5];
        logic [15:0] q;
        logic ov, dz, busy_ok;
        int lat;
        tbl[0] = '{16'h7F00, 16'h0010, 16'h7FFF, 1'b1};
        tbl[1] = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b1};
        tbl[2] = '{16'h8000, 16'h0100, 16'h8000, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0080, 16'h7FFF, 1'b1};
        tbl[4] = '{16'h8000, 16'h0080, 16'h8000, 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, q, ov, dz, lat, busy_ok);
            vectors++;
            if (q !== tbl[i].q || ov !== tbl[i].ov || dz !== 1'b0 || lat !== 25) begin
                errors++;
                $display("FAIL overflow_%0d %h/%h: q=%h ov=%b dz=%b lat=%0d, want %h %b 0 25",
                         i, tbl[i].a, tbl[i].b, q, ov, dz, lat, tbl[i].q, tbl[i].ov);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [15:0] q;
        logic ov, dz, busy_ok;
        int lat;
        run_op(16'hFE00, 16'h0000, q, ov, dz, lat, busy_ok);
        vectors++;
        if (q !== 16'h8000 || ov !== 1'b1 || dz !== 1'b1 || lat !== 0) begin
            errors++;
            $display("FAIL div_zero_neg: q=%h ov=%b dz=%b lat=%0d, want 8000 1 1 0", q, ov, dz, lat);
        end
        run_op(16'h0000, 16'h0000, q, ov, dz, lat, busy_ok);
        vectors++;
        if (q !== 16'h7FFF || ov !== 1'b1 || dz !== 1'b1 || lat !== 0) begin
            errors++;
            $display("FAIL div_zero_zero: q=%h ov=%b dz=%b lat=%0d, want 7fff 1 1 0", q, ov, dz, lat);
        end
        // Flags must clear on the following normal operation.
        run_op(16'h0300, 16'h0200, q, ov, dz, lat, busy_ok);
        vectors++;
        if (q !== 16'h0180 || ov !== 1'b0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_clear: q=%h ov=%b dz=%b, want 0180 0 0", q, ov, dz);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.dividend  = 16'h0300;
        bus.divisor   = 16'h0200;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat !== 25) begin
            errors++;
            $display("FAIL bp_latency: %0d edges, want 25", lat);
        end
        // New operands wait while the result is held.
        bus.dividend = 16'h0100;
        bus.divisor  = 16'h0100;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 16'h0180 ||
                bus.ovrflw !== 1'b0 || state_dbg !== DONE) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b q=%h ov=%b state=%0d, want 1 0 0180 0 DONE",
                         c, bus.out_valid, bus.in_ready, bus.quotient, bus.ovrflw, state_dbg);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (state_dbg !== IDLE || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: state=%0d out_valid=%b in_ready=%b, want IDLE 0 1",
                     state_dbg, bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        vectors++;
        if (state_dbg !== CALC) begin
            errors++;
            $display("FAIL bp_accept: state=%0d, want CALC", state_dbg);
        end
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (bus.quotient !== 16'h0100 || lat !== 25) begin
            errors++;
            $display("FAIL bp_second: q=%h lat=%0d, want 0100 25", bus.quotient, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] q;
        logic ov, dz, busy_ok;
        int lat;
        bus.dividend  = 16'h0300;
        bus.divisor   = 16'h0200;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        vectors++;
        if (state_dbg !== CALC) begin
            errors++;
            $display("FAIL mid_calc_state: state=%0d, want CALC", state_dbg);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || state_dbg !== IDLE || bus.quotient !== 16'h0000) begin
            errors++;
            $display("FAIL mid_calc_reset: out_valid=%b in_ready=%b state=%0d q=%h, want 0 1 IDLE 0000",
                     bus.out_valid, bus.in_ready, state_dbg, bus.quotient);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) break;
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_calc_no_result: out_valid=%b, want 0", bus.out_valid);
        end
        run_op(16'h0100, 16'h0100, q, ov, dz, lat, busy_ok);
        vectors++;
        if (q !== 16'h0100 || ov !== 1'b0 || lat !== 25) begin
            errors++;
            $display("FAIL after_reset_op: q=%h ov=%b lat=%0d, want 0100 0 25", q, ov, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_overflow();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
